// File: rtl/blaster_pkg.sv
// Shared types and default timing for the blaster high-voltage launch path.
package blaster_pkg;

    // Launch sequencer states. The encoding is also shown on the video overlay.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHARGE = 3'd1,
        READY  = 3'd2,
        FIRE   = 3'd3,
        DUMP   = 3'd4,
        FAULT  = 3'd5
    } launch_state_t;

    // Default timing at a 48 MHz system clock.
    localparam int unsigned DEF_DEBOUNCE_CYC       = 480_000;        // 10 ms
    localparam int unsigned DEF_CHARGE_TIMEOUT_CYC = 480_000_000;    // 10 s
    localparam int unsigned DEF_READY_TIMEOUT_CYC  = 1_440_000_000;  // 30 s
    localparam int unsigned DEF_FIRE_CYC           = 480_000;        // 10 ms
    localparam int unsigned DEF_PWM_PERIOD_CYC     = 1024;
    localparam int unsigned DEF_PWM_ON_CYC         = 64;
    localparam int unsigned DEF_DUMP_CYC           = 4_800_000;      // 100 ms
    localparam int unsigned DEF_TONE_DIV_BIT       = 14;
    localparam int unsigned DEF_BLINK_BIT          = 23;

    // Dwell timer width; wide enough for the 30 s ready timeout.
    localparam int TIMER_W = 31;
    // Free-running counter feeding the LED blink and the speaker tones.
    localparam int COUNT_W = 24;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-high counter and a
// single-cycle press pulse. A held button yields one pulse; the level has to
// drop before another press can be recognised.
module btn_debounce
    import blaster_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYC);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive high samples; pulse once when the threshold is hit,
    // then park the counter so holding the button cannot re-trigger.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else if (!r_sync2) begin
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= CNT_DONE;
            r_press <= 1'b1;
        end else begin
            r_press <= 1'b0;
            if (r_cnt != CNT_DONE) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/launch_sequencer.sv
// Safety sequencer for the blaster high-voltage path: arm, charge, ready,
// fire and dump. All outputs are registered from the next-state value so they
// switch on the same edge as the state register.
module launch_sequencer
    import blaster_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC       = DEF_DEBOUNCE_CYC,
    parameter int unsigned CHARGE_TIMEOUT_CYC = DEF_CHARGE_TIMEOUT_CYC,
    parameter int unsigned READY_TIMEOUT_CYC  = DEF_READY_TIMEOUT_CYC,
    parameter int unsigned FIRE_CYC           = DEF_FIRE_CYC,
    parameter int unsigned PWM_PERIOD_CYC     = DEF_PWM_PERIOD_CYC,
    parameter int unsigned PWM_ON_CYC         = DEF_PWM_ON_CYC,
    parameter int unsigned DUMP_CYC           = DEF_DUMP_CYC,
    parameter int unsigned TONE_DIV_BIT       = DEF_TONE_DIV_BIT,
    parameter int unsigned BLINK_BIT          = DEF_BLINK_BIT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       arm_button,
    input  logic       fire_button,
    input  logic       lt3420_done,
    input  logic       cont,
    output logic       lt3420_charge,
    output logic       pwm,
    output logic       dump,
    output logic       arm_led,
    output logic       cont_led,
    output logic       speaker,
    output logic [2:0] state,
    output logic       fault
);

    localparam int PH_W = (PWM_PERIOD_CYC > 1) ? $clog2(PWM_PERIOD_CYC) : 1;

    localparam logic [TIMER_W-1:0] T_CHARGE = TIMER_W'(CHARGE_TIMEOUT_CYC);
    localparam logic [TIMER_W-1:0] T_READY  = TIMER_W'(READY_TIMEOUT_CYC);
    localparam logic [TIMER_W-1:0] T_FIRE   = TIMER_W'(FIRE_CYC);
    localparam logic [TIMER_W-1:0] T_DUMP   = TIMER_W'(DUMP_CYC);
    localparam logic [PH_W-1:0]    PH_LAST  = PH_W'(PWM_PERIOD_CYC - 1);
    localparam logic [31:0]        PWM_ON_L = PWM_ON_CYC;

    launch_state_t      r_state;
    launch_state_t      w_next_state;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_next_timer;
    logic [PH_W-1:0]    r_phase;
    logic [PH_W-1:0]    w_next_phase;
    logic [TIMER_W-1:0] r_beep;
    logic [TIMER_W-1:0] w_next_beep;
    logic [COUNT_W-1:0] r_count;

    logic r_cont_s1, r_cont_s2;
    logic r_done_s1, r_done_s2;
    logic w_arm_press, w_fire_press;
    logic w_state_change;
    logic w_pwm_on;
    logic w_next_arm_led;
    logic w_next_speaker;
    logic w_count_unused;

    logic r_charge, r_pwm, r_dump, r_arm_led, r_speaker, r_fault;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_arm_db (
        .clk     (clk),
        .reset_n (reset_n),
        .i_raw   (arm_button),
        .o_press (w_arm_press)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_fire_db (
        .clk     (clk),
        .reset_n (reset_n),
        .i_raw   (fire_button),
        .o_press (w_fire_press)
    );

    // Two-flop synchronizers for continuity and charger-done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cont_s1 <= 1'b0;
            r_cont_s2 <= 1'b0;
            r_done_s1 <= 1'b0;
            r_done_s2 <= 1'b0;
        end else begin
            r_cont_s1 <= cont;
            r_cont_s2 <= r_cont_s1;
            r_done_s1 <= lt3420_done;
            r_done_s2 <= r_done_s1;
        end
    end

    // Free-running counter; its bits drive the LED blink and tone pitches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Next-state decision. Within each state the exits are listed in priority order.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_arm_press && r_cont_s2) w_next_state = CHARGE;
            end
            CHARGE: begin
                if (w_arm_press)              w_next_state = DUMP;
                else if (!r_cont_s2)          w_next_state = DUMP;
                else if (r_timer >= T_CHARGE) w_next_state = FAULT;
                else if (r_done_s2)           w_next_state = READY;
            end
            READY: begin
                if (w_arm_press)              w_next_state = DUMP;
                else if (!r_cont_s2)          w_next_state = DUMP;
                else if (r_timer >= T_READY)  w_next_state = DUMP;
                else if (w_fire_press)        w_next_state = FIRE;
            end
            FIRE: begin
                // Continuity loss is expected once the igniter burns through.
                if (r_timer >= T_FIRE)        w_next_state = DUMP;
            end
            DUMP: begin
                if (r_timer >= T_DUMP)        w_next_state = IDLE;
            end
            FAULT: begin
                if (w_arm_press)              w_next_state = DUMP;
            end
            default: w_next_state = FAULT;
        endcase
    end

    // Dwell timer and pwm phase restart on every state change; the phase
    // tracks timer modulo the pwm period without needing a divider.
    always_comb begin
        w_state_change = (w_next_state != r_state);
        if (w_state_change) begin
            w_next_timer = '0;
            w_next_phase = '0;
        end else begin
            w_next_timer = (r_timer == '1) ? r_timer : r_timer + 1'b1;
            w_next_phase = (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
        end
        w_pwm_on = (32'(w_next_phase) < PWM_ON_L);
    end

    // Beep window for an arm press without continuity.
    always_comb begin
        if (r_state == IDLE && w_arm_press && !r_cont_s2) begin
            w_next_beep = T_DUMP;
        end else if (r_beep != '0) begin
            w_next_beep = r_beep - 1'b1;
        end else begin
            w_next_beep = '0;
        end
    end

    // LED and speaker values for the state being entered.
    always_comb begin
        w_next_arm_led = 1'b0;
        w_next_speaker = 1'b0;
        case (w_next_state)
            CHARGE: w_next_arm_led = r_count[BLINK_BIT];
            READY: begin
                w_next_arm_led = 1'b1;
                w_next_speaker = r_count[TONE_DIV_BIT];
            end
            FIRE:  w_next_arm_led = 1'b1;
            FAULT: w_next_speaker = r_count[TONE_DIV_BIT-2];
            IDLE:  w_next_speaker = (w_next_beep != '0) && r_count[TONE_DIV_BIT];
            default: ;
        endcase
    end

    // State register, timers and every output advance together on one edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_phase   <= '0;
            r_beep    <= '0;
            r_charge  <= 1'b0;
            r_pwm     <= 1'b0;
            r_dump    <= 1'b1;
            r_arm_led <= 1'b0;
            r_speaker <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_timer   <= w_next_timer;
            r_phase   <= w_next_phase;
            r_beep    <= w_next_beep;
            r_charge  <= (w_next_state == CHARGE);
            r_pwm     <= (w_next_state == FIRE) && w_pwm_on;
            r_dump    <= (w_next_state == IDLE) || (w_next_state == DUMP) ||
                         (w_next_state == FAULT);
            r_arm_led <= w_next_arm_led;
            r_speaker <= w_next_speaker;
            r_fault   <= (w_next_state == FAULT);
        end
    end

    // Only a few counter bits feed outputs; fold the rest away.
    assign w_count_unused = ^r_count;

    assign lt3420_charge = r_charge;
    assign pwm           = r_pwm;
    assign dump          = r_dump;
    assign arm_led       = r_arm_led;
    assign cont_led      = r_cont_s2;
    assign speaker       = r_speaker;
    assign state         = r_state;
    assign fault         = r_fault;

`ifndef SYNTHESIS
    a_pwm_dump:   assert property (@(posedge clk) disable iff (!reset_n) !(r_pwm && r_dump));
    a_pwm_charge: assert property (@(posedge clk) disable iff (!reset_n) !(r_pwm && r_charge));
    a_pwm_fire:   assert property (@(posedge clk) disable iff (!reset_n) r_pwm |-> (r_state == FIRE));
    a_chg_charge: assert property (@(posedge clk) disable iff (!reset_n) r_charge |-> (r_state == CHARGE));
`endif

endmodule

// File: tb/tb_launch_sequencer.sv
// Bench for launch_sequencer with shortened timing.
module tb_launch_sequencer;
    import blaster_pkg::*;

    localparam int DEB    = 4;
    localparam int CHG_TO = 200;
    localparam int RDY_TO = 300;
    localparam int FIRE_C = 40;
    localparam int PWM_P  = 8;
    localparam int PWM_ON = 2;
    localparam int DUMP_C = 20;
    localparam int TONE   = 2;
    localparam int BLINK  = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       arm_button, fire_button, lt3420_done, cont;
    logic       lt3420_charge, pwm, dump, arm_led, cont_led, speaker, fault;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    // scoreboard: expected state sequence
    logic [2:0] exp_q[$];
    logic [2:0] seen_state = 3'd0;

    // monitor bookkeeping
    logic [2:0] mon_state    = 3'd0;
    int         dwell        = 0;
    int         last_dwell   = 0;
    int         fire_t       = 0;
    int         pwm_total    = 0;
    int         charge_total = 0;
    int         spk_toggles  = 0;
    logic       prev_spk     = 1'b0;

    int snap_a;
    int snap_b;
    int exp_hi;
    int n;

    launch_sequencer #(
        .DEBOUNCE_CYC       (DEB),
        .CHARGE_TIMEOUT_CYC (CHG_TO),
        .READY_TIMEOUT_CYC  (RDY_TO),
        .FIRE_CYC           (FIRE_C),
        .PWM_PERIOD_CYC     (PWM_P),
        .PWM_ON_CYC         (PWM_ON),
        .DUMP_CYC           (DUMP_C),
        .TONE_DIV_BIT       (TONE),
        .BLINK_BIT          (BLINK)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .arm_button    (arm_button),
        .fire_button   (fire_button),
        .lt3420_done   (lt3420_done),
        .cont          (cont),
        .lt3420_charge (lt3420_charge),
        .pwm           (pwm),
        .dump          (dump),
        .arm_led       (arm_led),
        .cont_led      (cont_led),
        .speaker       (speaker),
        .state         (state),
        .fault         (fault)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drive_buttons(input logic a, input logic f, input int cycles);
        arm_button  = a;
        fire_button = f;
        tick(cycles);
        arm_button  = 1'b0;
        fire_button = 1'b0;
        tick(1);
    endtask

    // wait for the next state change and compare it with the queue head
    task automatic expect_next(input string tag, input int budget);
        logic [2:0] exp;
        int waited;
        exp = exp_q.pop_front();
        waited = 0;
        while (state == seen_state && waited < budget) begin
            tick(1);
            waited++;
        end
        check({tag, "_in_time"}, 32'(waited < budget), 32'd1);
        check(tag, 32'(state), 32'(exp));
        seen_state = state;
    endtask

    task automatic go_charge();
        exp_q.push_back(CHARGE);
        drive_buttons(1'b1, 1'b0, 10);
        expect_next("to_charge", 20);
    endtask

    task automatic go_ready();
        go_charge();
        exp_q.push_back(READY);
        lt3420_done = 1'b1;
        expect_next("to_ready", 10);
        lt3420_done = 1'b0;
    endtask

    task automatic go_fire();
        go_ready();
        exp_q.push_back(FIRE);
        drive_buttons(1'b0, 1'b1, 10);
        expect_next("to_fire", 20);
    endtask

    task automatic back_to_idle(input string tag);
        exp_q.push_back(IDLE);
        expect_next(tag, DUMP_C + 40);
    endtask

    // per-cycle monitor: dwell lengths, pwm pattern and safety invariants
    always @(negedge clk) begin
        if (state == mon_state) begin
            dwell <= dwell + 1;
        end else begin
            last_dwell <= dwell;
            dwell      <= 1;
        end
        mon_state <= state;
        if (state == FIRE) begin
            check("fire_pwm", 32'(pwm), 32'(((fire_t % PWM_P) < PWM_ON) ? 1 : 0));
            fire_t <= fire_t + 1;
        end else begin
            fire_t <= 0;
        end
        if (pwm)           pwm_total    <= pwm_total + 1;
        if (lt3420_charge) charge_total <= charge_total + 1;
        if (speaker != prev_spk) spk_toggles <= spk_toggles + 1;
        prev_spk <= speaker;
        check("pwm_and_dump",   32'(pwm & dump), 32'd0);
        check("pwm_and_charge", 32'(pwm & lt3420_charge), 32'd0);
        check("pwm_off_fire",   32'(pwm && state != FIRE), 32'd0);
        check("chg_off_charge", 32'(lt3420_charge && state != CHARGE), 32'd0);
    end

    initial begin
        reset_n     = 1'b1;
        arm_button  = 1'b0;
        fire_button = 1'b0;
        lt3420_done = 1'b0;
        cont        = 1'b0;
        #2 reset_n = 1'b0;
        tick(1);

        // reset state
        check("rst_state",   32'(state), 32'(IDLE));
        check("rst_dump",    32'(dump), 32'd1);
        check("rst_pwm",     32'(pwm), 32'd0);
        check("rst_charge",  32'(lt3420_charge), 32'd0);
        check("rst_fault",   32'(fault), 32'd0);
        check("rst_speaker", 32'(speaker), 32'd0);
        check("rst_arm_led", 32'(arm_led), 32'd0);
        tick(2);
        reset_n    = 1'b1;
        seen_state = IDLE;
        tick(2);

        // 1. normal shot
        cont = 1'b1;
        tick(4);
        check("cont_led", 32'(cont_led), 32'd1);
        go_charge();
        check("charge_on", 32'(lt3420_charge), 32'd1);
        check("charge_dump_off", 32'(dump), 32'd0);
        exp_q.push_back(READY);
        lt3420_done = 1'b1;
        expect_next("to_ready", 10);
        lt3420_done = 1'b0;
        check("ready_charge_off", 32'(lt3420_charge), 32'd0);
        check("ready_arm_led", 32'(arm_led), 32'd1);
        snap_a = pwm_total;
        exp_q.push_back(FIRE);
        drive_buttons(1'b0, 1'b1, 10);
        expect_next("to_fire", 20);
        exp_q.push_back(DUMP);
        expect_next("fire_end", FIRE_C + 20);
        // the cycle where the timer reaches FIRE_C is still spent in FIRE
        check("fire_dwell", 32'(last_dwell), 32'(FIRE_C + 1));
        exp_hi = 0;
        for (int t = 0; t <= FIRE_C; t++) if ((t % PWM_P) < PWM_ON) exp_hi++;
        check("fire_pwm_count", 32'(pwm_total - snap_a), 32'(exp_hi));
        check("dump_on", 32'(dump), 32'd1);
        back_to_idle("dump_end");
        check("dump_dwell", 32'(last_dwell), 32'(DUMP_C + 1));

        // 2. no continuity: beep, no charge
        cont = 1'b0;
        tick(4);
        snap_a = spk_toggles;
        snap_b = charge_total;
        drive_buttons(1'b1, 1'b0, 10);
        tick(15);
        check("nocont_state", 32'(state), 32'(IDLE));
        check("nocont_beep", 32'((spk_toggles - snap_a) > 0), 32'd1);
        check("nocont_no_charge", 32'(charge_total - snap_b), 32'd0);
        tick(30);
        check("beep_end", 32'(speaker), 32'd0);

        // 3. charge timeout -> FAULT, arm press clears it
        cont = 1'b1;
        tick(4);
        go_charge();
        exp_q.push_back(FAULT);
        expect_next("charge_timeout", CHG_TO + 20);
        check("timeout_dwell", 32'(last_dwell), 32'(CHG_TO + 1));
        check("fault_flag", 32'(fault), 32'd1);
        check("fault_dump", 32'(dump), 32'd1);
        snap_a = spk_toggles;
        tick(4);
        check("fault_tone", 32'((spk_toggles - snap_a) > 0), 32'd1);
        exp_q.push_back(DUMP);
        drive_buttons(1'b1, 1'b0, 10);
        expect_next("fault_exit", 5);
        back_to_idle("fault_to_idle");
        check("fault_clear", 32'(fault), 32'd0);

        // 4. arm and fire together in READY: abort wins
        go_ready();
        snap_a = pwm_total;
        exp_q.push_back(DUMP);
        drive_buttons(1'b1, 1'b1, 10);
        expect_next("abort", 5);
        back_to_idle("abort_to_idle");
        check("abort_no_pwm", 32'(pwm_total - snap_a), 32'd0);

        // 5. continuity lost in CHARGE, READY, FIRE
        go_charge();
        cont = 1'b0;
        exp_q.push_back(DUMP);
        expect_next("cont_lost_charge", 6);
        back_to_idle("cl_charge_idle");
        cont = 1'b1;
        tick(4);
        go_ready();
        cont = 1'b0;
        exp_q.push_back(DUMP);
        expect_next("cont_lost_ready", 6);
        back_to_idle("cl_ready_idle");
        cont = 1'b1;
        tick(4);
        go_fire();
        cont = 1'b0;
        exp_q.push_back(DUMP);
        expect_next("cont_lost_fire", FIRE_C + 20);
        check("cl_fire_dwell", 32'(last_dwell), 32'(FIRE_C + 1));
        back_to_idle("cl_fire_idle");
        cont = 1'b1;
        tick(4);

        // 6. asynchronous reset in the middle of FIRE
        go_fire();
        n = 0;
        while (!pwm && n < 2 * PWM_P) begin
            tick(1);
            n++;
        end
        check("pwm_before_reset", 32'(pwm), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_pwm",   32'(pwm), 32'd0);
        check("async_rst_dump",  32'(dump), 32'd1);
        check("async_rst_state", 32'(state), 32'(IDLE));
        check("async_rst_chg",   32'(lt3420_charge), 32'd0);
        exp_q.delete();
        seen_state = IDLE;
        tick(2);
        reset_n = 1'b1;
        tick(4);

        // bounce: 3-cycle glitches on fire must not fire
        go_ready();
        repeat (3) begin
            fire_button = 1'b1;
            tick(3);
            fire_button = 1'b0;
            tick(3);
        end
        tick(5);
        check("bounce_no_fire", 32'(state), 32'(READY));
        exp_q.push_back(DUMP);
        drive_buttons(1'b1, 1'b0, 10);
        expect_next("bounce_abort", 5);
        back_to_idle("bounce_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
